// File: rtl/exc_vector_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exc_pkg
// Brief    : Shared select codes, cause codes and FSM states for the
//            exception vector fetch sequencer and the memory-address mux.
// Revision : 1.0 - initial release
// ============================================================================
package exc_pkg;

    // Memory-address mux select codes, shared with the address mux itself
    localparam logic [2:0] SEL_PC  = 3'b000;
    localparam logic [2:0] SEL_253 = 3'b010;
    localparam logic [2:0] SEL_254 = 3'b011;
    localparam logic [2:0] SEL_255 = 3'b100;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_OPC  = 2'b01;
    localparam logic [1:0] CAUSE_OVF  = 2'b10;
    localparam logic [1:0] CAUSE_DIV0 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_LOAD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/exc_vector_fetch_priority_enc.sv
`default_nettype none
// ============================================================================
// Module   : exc_priority_enc
// Brief    : Fixed-priority encoder (opcode > overflow > div0) producing the
//            exception cause and the matching vector-byte select code.
// Revision : 1.0 - initial release
// ============================================================================
module exc_priority_enc
    import exc_pkg::*;
(
    input  logic       exc_opcode,
    input  logic       exc_overflow,
    input  logic       exc_div0,
    output logic       valid,
    output logic [1:0] cause,
    output logic [2:0] sel
);

    always_comb begin
        valid = 1'b1;
        cause = CAUSE_NONE;
        sel   = SEL_PC;
        if (exc_opcode) begin
            cause = CAUSE_OPC;
            sel   = SEL_253;
        end else if (exc_overflow) begin
            cause = CAUSE_OVF;
            sel   = SEL_254;
        end else if (exc_div0) begin
            cause = CAUSE_DIV0;
            sel   = SEL_255;
        end else begin
            valid = 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/exc_vector_fetch.sv
`default_nettype none
// ============================================================================
// Module   : exc_vector_fetch
// Brief    : Exception sequencer: saves EPC, selects the vector byte address,
//            waits out memory latency and loads PC with the handler byte.
// Revision : 1.0 - initial release
// ============================================================================
module exc_vector_fetch
    import exc_pkg::*;
#(
    parameter int MEM_LAT   = 2,
    parameter int PC_OFFSET = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [2:0]  mem_adrs_sel,
    output logic [31:0] epc_out,
    output logic        epc_write,
    output logic [31:0] pc_out,
    output logic        pc_write,
    output logic [1:0]  exc_cause,
    output logic        busy,
    output logic        done,
    output logic        missed
);

    localparam logic [3:0]  c_cnt_last  = 4'(MEM_LAT - 1);
    localparam logic [31:0] c_pc_offset = 32'(PC_OFFSET);

    state_t     r_state;
    logic [3:0] r_cnt;

    logic       w_valid;
    logic [1:0] w_cause;
    logic [2:0] w_sel;
    logic       w_unused_data;

    assign w_unused_data = ^mem_data_in[31:8];

    exc_priority_enc u_prio (
        .exc_opcode   (exc_opcode),
        .exc_overflow (exc_overflow),
        .exc_div0     (exc_div0),
        .valid        (w_valid),
        .cause        (w_cause),
        .sel          (w_sel)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            mem_adrs_sel <= SEL_PC;
            epc_out      <= 32'd0;
            epc_write    <= 1'b0;
            pc_out       <= 32'd0;
            pc_write     <= 1'b0;
            exc_cause    <= CAUSE_NONE;
            busy         <= 1'b0;
            done         <= 1'b0;
            missed       <= 1'b0;
        end else begin
            epc_write <= 1'b0;
            pc_write  <= 1'b0;
            done      <= 1'b0;

            if (r_state != ST_IDLE && w_valid) begin
                missed <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        exc_cause    <= w_cause;
                        epc_out      <= pc_in - c_pc_offset;
                        mem_adrs_sel <= w_sel;
                        epc_write    <= 1'b1;
                        busy         <= 1'b1;
                        r_cnt        <= 4'd0;
                        r_state      <= ST_WAIT;
                    end else begin
                        mem_adrs_sel <= SEL_PC;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 4'd1;
                    // The PC load happens on the edge entering LOAD, so the
                    // LOAD cycle is the one carrying the pc_write strobe.
                    if (r_cnt == c_cnt_last) begin
                        pc_out   <= {24'd0, mem_data_in[7:0]};
                        pc_write <= 1'b1;
                        r_state  <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    mem_adrs_sel <= SEL_PC;
                    done         <= 1'b1;
                    r_state      <= ST_DONE;
                end
                ST_DONE: begin
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_exc_vector_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_exc_vector_fetch
// Brief    : Self-checking bench for exc_vector_fetch at MEM_LAT = 1, 2, 5.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exc_vector_fetch;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        exc_opcode = 1'b0;
    logic        exc_overflow = 1'b0;
    logic        exc_div0 = 1'b0;
    logic [31:0] pc_in = 32'd0;
    logic [31:0] mem_fixed = 32'd0;
    logic [31:0] mem_vary_data = 32'd0;
    logic        mem_vary = 1'b0;
    logic [31:0] mem_data_in;

    logic [2:0]  sel_o    [3];
    logic [31:0] epc_o    [3];
    logic [31:0] pcout_o  [3];
    logic        epcw_o   [3];
    logic        pcw_o    [3];
    logic [1:0]  cause_o  [3];
    logic        busy_o   [3];
    logic        done_o   [3];
    logic        missed_o [3];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit model_ok = 1'b0;

    assign mem_data_in = mem_vary ? mem_vary_data : mem_fixed;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            exc_vector_fetch #(
                .MEM_LAT   ((gi == 0) ? 1 : ((gi == 1) ? 2 : 5)),
                .PC_OFFSET (4)
            ) u_dut (
                .clk          (clk),
                .reset        (reset),
                .exc_opcode   (exc_opcode),
                .exc_overflow (exc_overflow),
                .exc_div0     (exc_div0),
                .pc_in        (pc_in),
                .mem_data_in  (mem_data_in),
                .mem_adrs_sel (sel_o[gi]),
                .epc_out      (epc_o[gi]),
                .epc_write    (epcw_o[gi]),
                .pc_out       (pcout_o[gi]),
                .pc_write     (pcw_o[gi]),
                .exc_cause    (cause_o[gi]),
                .busy         (busy_o[gi]),
                .done         (done_o[gi]),
                .missed       (missed_o[gi])
            );
        end
    endgenerate

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : ((i == 1) ? 2 : 5);
    endfunction

    // Low byte changes every cycle (odd multiplier) so an off-by-one sample is visible
    always @(negedge clk) begin
        cyc <= cyc + 1;
        mem_vary_data <= 32'(cyc) * 32'h9E37_79B1;
    end

    // Model: every output is a function of edges elapsed since acceptance (k)
    int          k      [3];
    bit          act    [3];
    logic [2:0]  m_code [3];
    logic [2:0]  m_sel  [3];
    logic [31:0] m_epc  [3];
    logic [31:0] m_pc   [3];
    logic [1:0]  m_cause[3];
    bit          m_epcw [3];
    bit          m_pcw  [3];
    bit          m_busy [3];
    bit          m_done [3];
    bit          m_missed[3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            automatic int       lat = lat_of(i);
            automatic int       kn;
            automatic bit       a;
            automatic bit       req = exc_opcode | exc_overflow | exc_div0;
            automatic logic [2:0] code;
            if (reset) begin
                act[i] <= 1'b0;     k[i] <= 0;          m_code[i] <= 3'd0;
                m_sel[i] <= 3'd0;   m_epc[i] <= 32'd0;  m_pc[i] <= 32'd0;
                m_cause[i] <= 2'd0; m_epcw[i] <= 1'b0;  m_pcw[i] <= 1'b0;
                m_busy[i] <= 1'b0;  m_done[i] <= 1'b0;  m_missed[i] <= 1'b0;
                model_ok <= 1'b1;
            end else begin
                a    = act[i];
                kn   = (k[i] < 1000) ? k[i] + 1 : k[i];
                code = m_code[i];
                if (a && kn <= lat + 2) begin
                    if (req) m_missed[i] <= 1'b1;
                end else if (req) begin
                    a  = 1'b1;
                    kn = 0;
                    if (exc_opcode)        begin code = 3'b010; m_cause[i] <= 2'b01; end
                    else if (exc_overflow) begin code = 3'b011; m_cause[i] <= 2'b10; end
                    else                   begin code = 3'b100; m_cause[i] <= 2'b11; end
                    m_epc[i] <= pc_in - 32'd4;
                end
                act[i]    <= a;
                k[i]      <= kn;
                m_code[i] <= code;
                m_epcw[i] <= a && (kn == 0);
                m_sel[i]  <= (a && kn <= lat) ? code : 3'd0;
                m_pcw[i]  <= a && (kn == lat);
                m_done[i] <= a && (kn == lat + 1);
                m_busy[i] <= a && (kn <= lat + 1);
                if (a && kn == lat) m_pc[i] <= {24'd0, mem_data_in[7:0]};
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            for (int i = 0; i < 3; i++) begin
                automatic logic [73:0] got = {sel_o[i], epc_o[i], pcout_o[i], cause_o[i],
                    epcw_o[i], pcw_o[i], busy_o[i], done_o[i], missed_o[i]};
                automatic logic [73:0] exp = {m_sel[i], m_epc[i], m_pc[i], m_cause[i],
                    m_epcw[i], m_pcw[i], m_busy[i], m_done[i], m_missed[i]};
                tests++;
                if (got !== exp) begin
                    fails++;
                    $display("FAIL model cyc=%0d lat=%0d got sel/epc/pc/cause/ew,pw,b,d,m=%h expected %h",
                             cyc, lat_of(i), got, exp);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act_v, exp_v);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        automatic int n;
        automatic int pw_seen;

        step(2);
        check("rst_sel",    32'(sel_o[1]),    32'd0);
        check("rst_epc",    epc_o[1],         32'd0);
        check("rst_pc",     pcout_o[1],       32'd0);
        check("rst_cause",  32'(cause_o[1]),  32'd0);
        check("rst_busy",   32'(busy_o[1]),   32'd0);
        check("rst_missed", 32'(missed_o[1]), 32'd0);

        // div0 with MEM_LAT=2
        reset = 1'b0;
        mem_fixed = 32'h0000_1177;
        pc_in = 32'h40;
        exc_div0 = 1'b1;
        step();
        exc_div0 = 1'b0;
        check("div0_cause", 32'(cause_o[1]), 32'd3);
        check("div0_sel",   32'(sel_o[1]),   32'd4);
        check("div0_epcw",  32'(epcw_o[1]),  32'd1);
        check("div0_epc",   epc_o[1],        32'h3C);
        step(2);
        check("div0_pcw",   32'(pcw_o[1]),   32'd1);
        check("div0_pc",    pcout_o[1],      32'h77);
        step(10);

        // Simultaneous opcode + overflow: opcode wins
        mem_fixed = 32'h1234_56A5;
        pc_in = 32'h100;
        exc_opcode = 1'b1;
        exc_overflow = 1'b1;
        step();
        exc_opcode = 1'b0;
        exc_overflow = 1'b0;
        check("prio_sel",   32'(sel_o[1]),    32'd2);
        check("prio_cause", 32'(cause_o[1]),  32'd1);
        check("prio_epc",   epc_o[1],         32'hFC);
        step(2);
        check("prio_pc",    pcout_o[1],       32'hA5);
        step();
        check("prio_done",  32'(done_o[1]),   32'd1);
        check("prio_nomiss", 32'(missed_o[1]), 32'd0);
        step(10);

        // Request during WAIT is missed and stays sticky
        exc_overflow = 1'b1;
        step();
        exc_overflow = 1'b0;
        step();
        exc_overflow = 1'b1;
        step();
        exc_overflow = 1'b0;
        check("miss_set", 32'(missed_o[1]), 32'd1);
        step(10);
        exc_div0 = 1'b1;
        step();
        exc_div0 = 1'b0;
        step(10);
        check("miss_sticky", 32'(missed_o[1]), 32'd1);

        // Reset in WAIT aborts the fetch
        exc_opcode = 1'b1;
        step();
        exc_opcode = 1'b0;
        step();
        check("abort_busy_before", 32'(busy_o[1]), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_sel",    32'(sel_o[1]),    32'd0);
        check("abort_busy",   32'(busy_o[1]),   32'd0);
        check("abort_missed", 32'(missed_o[1]), 32'd0);
        pw_seen = 0;
        for (int j = 0; j < 10; j++) begin
            step();
            if (pcw_o[1] || pcw_o[2]) pw_seen++;
        end
        check("abort_no_pcw", 32'(pw_seen), 32'd0);

        // Latency sweep with per-cycle changing memory data
        mem_vary = 1'b1;
        for (int i = 0; i < 3; i += 2) begin
            pc_in = 32'h2000 + 32'(i);
            exc_overflow = 1'b1;
            step();
            exc_overflow = 1'b0;
            n = 0;
            while (!pcw_o[i] && n < 20) begin
                step();
                n++;
            end
            check($sformatf("lat%0d_pcw_delay", lat_of(i)), 32'(n), 32'(lat_of(i)));
            step(10);
        end

        // Directed request table with assorted gaps
        for (int t = 0; t < 8; t++) begin
            automatic logic [2:0] pat = 3'(t);
            if (pat == 3'd0) pat = 3'b101;
            pc_in = 32'h1000 * 32'(t) + 32'h8;
            {exc_opcode, exc_overflow, exc_div0} = pat;
            step();
            {exc_opcode, exc_overflow, exc_div0} = 3'b000;
            step(t + 1);
        end
        step(12);

        // Wrap and back-to-back held request
        mem_vary = 1'b0;
        pc_in = 32'h0;
        exc_div0 = 1'b1;
        step();
        check("wrap_epc", epc_o[1], 32'hFFFF_FFFC);
        n = 0;
        while (!done_o[1] && n < 20) begin
            step();
            n++;
        end
        check("b2b_done_seen", 32'(done_o[1]), 32'd1);
        n = 0;
        do begin
            step();
            n++;
        end while (!epcw_o[1] && n < 20);
        check("b2b_gap", 32'(n), 32'd2);
        exc_div0 = 1'b0;
        step(15);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/exc_vector_fetch.md
Name: exc_vector_fetch

Overview:
- Sequencer that consumes the fixed exception addresses 253/254/255 on the memory-address path.
- On an exception request it:
  - saves the return address to EPC;
  - drives the memory address-select code for the matching vector byte;
  - waits out memory read latency;
  - loads PC with the zero-extended handler byte.
- Sits beside the main control unit. It is the control side that produces the select codes and reads back the vector data.

Parameters:
- MEM_LAT, 2, memory read latency in cycles from address-select change to valid mem_data_in (legal 1..15).
- PC_OFFSET, 4, value subtracted from pc_in to form EPC.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- exc_opcode  input  1  invalid-opcode exception request (level, sampled in IDLE).
- exc_overflow  input  1  arithmetic-overflow request.
- exc_div0  input  1  divide-by-zero request.
- pc_in  input  32  current PC, sampled on acceptance.
- mem_data_in  input  32  memory read data; bits [7:0] are the vector byte.
- mem_adrs_sel  output  3  memory-address mux select: 3'b010 (253), 3'b011 (254), 3'b100 (255); 3'b000 (PC) when not driving.
- epc_out  output  32  pc_in − PC_OFFSET, captured at acceptance.
- epc_write  output  1  one-cycle EPC write strobe.
- pc_out  output  32  handler address {24'b0, vector byte}.
- pc_write  output  1  one-cycle PC write strobe.
- exc_cause  output  2  01 opcode, 10 overflow, 11 div0, 00 none; held until next acceptance.
- busy  output  1  high while a fetch is in progress.
- done  output  1  one-cycle completion pulse.
- missed  output  1  sticky; set when a request is asserted while busy; cleared only by reset.

Behaviour:
- Reset:
  - state=IDLE; counter=0.
  - All outputs 0: mem_adrs_sel=3'b000, epc_out=0, pc_out=0, exc_cause=00, missed=0.
  - Reset has priority over everything and aborts any in-flight fetch the same edge. No strobe fires after reset.
- All outputs are registered.
- States: IDLE, WAIT, LOAD, DONE.
- IDLE:
  - If any request is high at edge T, accept it. Priority is opcode > overflow > div0.
  - Latch exc_cause, epc_out=pc_in−PC_OFFSET (mod 2^32, so pc_in=0 gives FFFFFFFC).
  - Set mem_adrs_sel to the matching code, epc_write=1, busy=1, counter=0. Go to WAIT.
  - With no request, stay in IDLE with mem_adrs_sel=000.
- WAIT:
  - epc_write returns to 0 after exactly one cycle. mem_adrs_sel is held.
  - Counter increments each cycle. When counter==MEM_LAT−1, go to LOAD on that edge.
  - Total cycles with the select held before the LOAD edge = MEM_LAT.
- LOAD:
  - On the LOAD edge, pc_out={24'b0, mem_data_in[7:0]} and pc_write=1 for one cycle.
  - mem_data_in is sampled exactly MEM_LAT cycles after the select first appeared.
  - Go to DONE.
- DONE:
  - pc_write=0, mem_adrs_sel=000, done=1 for one cycle, busy=0 on the following edge. Return to IDLE.
  - A request present in DONE is not accepted. It is accepted in IDLE the next cycle.
- Latency: acceptance edge T → pc_write high at T+MEM_LAT+1 → done high at T+MEM_LAT+2.
- Simultaneous requests: only the highest priority is serviced. Lower ones are not queued and do not set missed.
- Requests while busy (WAIT/LOAD/DONE): ignored, and missed is set.
- epc_out and exc_cause hold their values until the next acceptance. pc_out holds until the next LOAD.

Decomposition:
- Shared package exc_pkg holds:
  - select codes SEL_PC=3'b000, SEL_253=3'b010, SEL_254=3'b011, SEL_255=3'b100;
  - cause codes CAUSE_NONE/OPC/OVF/DIV0;
  - FSM state enum.
- The same select constants are used by the address mux and by the control unit.
- One natural sub-module: exc_priority_enc (combinational 3-request → cause + select code). The FSM, counter and output registers stay in the top.

Test Plan:
- Reset values: assert reset 2 cycles → all outputs 0, busy=0. Then pulse exc_div0 with pc_in=0x40 → cause=11, sel=100 at T+1, epc_write=1 with epc_out=0x3C, pc_write at T+3 (MEM_LAT=2).
- Priority: exc_opcode and exc_overflow high the same cycle, pc_in=0x100, mem_data_in[7:0]=0xA5 → sel=010, cause=01, epc_out=0xFC, pc_out=0x000000A5, done at T+4.
- Miss: raise exc_overflow during WAIT → ignored, missed=1 and stays 1 through later fetches until reset.
- Reset mid-operation: assert reset in WAIT → next edge sel=000, busy=0, and no pc_write ever fires for that fetch.
- Latency sweep: MEM_LAT=1 and MEM_LAT=5 → pc_write exactly MEM_LAT+1 cycles after acceptance. mem_data_in changed one cycle early/late must not appear in pc_out.
- Wrap: pc_in=0x00000000 → epc_out=0xFFFFFFFC. Back-to-back request held high through DONE → second acceptance exactly one cycle after done.
